cmd_frame_deser: RTL and testbench

- Serial command-frame deserializer; sits directly upstream of the monitor command registers.
- Takes pre-decoded serial bits, assembles fixed 48-bit frames (8-bit address, 32-bit data, 8-bit CRC) and checks the CRC.
- On a good frame, presents addrOut/dataOut and a one-cycle latchOut strobe, which all command/config registers on the bus decode.
- Detects inter-bit gap timeouts and CRC failures; keeps good-frame and error counters.

---
 rtl/cmd_frame_deser_pkg.sv | 22 ++
 rtl/crc8_serial.sv | 40 ++++
 rtl/cmd_frame_deser.sv | 180 ++++++++++++++++++
 tb/tb_cmd_frame_deser.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cmd_frame_deser_pkg.sv
// Shared constants and helpers for the command-frame deserializer.
package cmd_frame_deser_pkg;

    localparam int FRAME_BITS = 48;
    localparam int ADDR_W     = 8;
    localparam int DATA_W     = 32;
    localparam int CRC_W      = 8;
    localparam int CNT_BITS   = 6;

    localparam logic [CRC_W-1:0] CRC_POLY_DEF = 8'h07;

    // Frame FSM encoding
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RECV  = 2'd1;
    localparam logic [1:0] ST_CHECK = 2'd2;

    // Saturating 8-bit increment used by the error counter
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/crc8_serial.sv
// Bit-serial CRC-8, MSB first, no reflection, no output XOR.
// clr_i restarts from zero; when clr_i and en_i are both set the bit is
// folded into the freshly cleared register. crc_nxt_o is the remainder
// including this cycle's bit, so a caller can judge a frame on the same
// edge that samples its last bit.
module crc8_serial
    import cmd_frame_deser_pkg::*;
#(
    parameter logic [CRC_W-1:0] POLY = CRC_POLY_DEF
) (
    input  logic             bclk,
    input  logic             rstb,
    input  logic             clr_i,
    input  logic             en_i,
    input  logic             bit_i,
    output logic [CRC_W-1:0] crc_nxt_o
);

    logic [CRC_W-1:0] crc_q;
    logic [CRC_W-1:0] crc_d;
    logic [CRC_W-1:0] base;

    // Next remainder: optional clear, then optional one-bit LFSR step
    always_comb begin
        base  = clr_i ? '0 : crc_q;
        crc_d = base;
        if (en_i) begin
            crc_d = {base[CRC_W-2:0], 1'b0} ^ ((base[CRC_W-1] ^ bit_i) ? POLY : '0);
        end
    end

    // Remainder register
    always_ff @(posedge bclk or negedge rstb) begin
        if (!rstb) crc_q <= '0;
        else       crc_q <= crc_d;
    end

    assign crc_nxt_o = crc_d;

endmodule

// File: rtl/cmd_frame_deser.sv
// Serial command-frame deserializer: assembles addr/data/crc frames,
// validates the CRC and publishes good frames to the command registers.
//
//   state    | meaning
//   ---------+-------------------------------------------------------
//   IDLE     | no frame in progress, waiting for the first bit
//   RECV     | collecting bits 2..48, gap timer running between bits
//   CHECK    | one cycle: latchOut or crc_err visible, datapath cleared
module cmd_frame_deser
    import cmd_frame_deser_pkg::*;
#(
    parameter int               GAP_TIMEOUT = 1024,
    parameter int               CNT_W       = 11,
    parameter logic [CRC_W-1:0] CRC_POLY    = CRC_POLY_DEF
) (
    input  logic              bclk,
    input  logic              rstb,
    input  logic              bit_valid,
    input  logic              bit_data,
    output logic [ADDR_W-1:0] addrOut,
    output logic [DATA_W-1:0] dataOut,
    output logic              latchOut,
    output logic              crc_err,
    output logic              gap_err,
    output logic [7:0]        good_cnt,
    output logic [7:0]        err_cnt
);

    localparam int SH_W = FRAME_BITS - 1;
    localparam logic [CNT_BITS-1:0] LAST_BIT = CNT_BITS'(FRAME_BITS - 1);
    localparam logic [CNT_W-1:0]    GAP_LAST = CNT_W'(GAP_TIMEOUT - 1);

    // Only 47 bits are stored; the 48th is on bit_data when the frame is judged.
    logic [1:0]          state_q,   state_d;
    logic [SH_W-1:0]     shift_q,   shift_d;
    logic [CNT_BITS-1:0] cnt_q,     cnt_d;
    logic [CNT_W-1:0]    gap_q,     gap_d;
    logic [ADDR_W-1:0]   addr_q,    addr_d;
    logic [DATA_W-1:0]   data_q,    data_d;
    logic                latch_q,   latch_d;
    logic                crc_err_q, crc_err_d;
    logic                gap_err_q, gap_err_d;
    logic [7:0]          good_q,    good_d;
    logic [7:0]          err_q,     err_d;

    logic                crc_clr;
    logic                crc_en;
    logic [CRC_W-1:0]    crc_nxt;

    crc8_serial #(.POLY(CRC_POLY)) u_crc (
        .bclk      (bclk),
        .rstb      (rstb),
        .clr_i     (crc_clr),
        .en_i      (crc_en),
        .bit_i     (bit_data),
        .crc_nxt_o (crc_nxt)
    );

    // Frame FSM and datapath next-state
    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        cnt_d     = cnt_q;
        gap_d     = gap_q;
        addr_d    = addr_q;
        data_d    = data_q;
        latch_d   = 1'b0;
        crc_err_d = 1'b0;
        gap_err_d = 1'b0;
        good_d    = good_q;
        err_d     = err_q;
        crc_clr   = 1'b0;
        crc_en    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bit_valid) begin
                    shift_d = {{(SH_W-1){1'b0}}, bit_data};
                    cnt_d   = CNT_BITS'(1);
                    gap_d   = '0;
                    crc_clr = 1'b1;
                    crc_en  = 1'b1;
                    state_d = ST_RECV;
                end
            end

            ST_RECV: begin
                if (bit_valid) begin
                    shift_d = {shift_q[SH_W-2:0], bit_data};
                    cnt_d   = cnt_q + CNT_BITS'(1);
                    gap_d   = '0;
                    crc_en  = 1'b1;
                    if (cnt_q == LAST_BIT) begin
                        state_d = ST_CHECK;
                        if (crc_nxt == '0) begin
                            // {shift_q, bit_data} is the whole frame: addr at the top
                            latch_d = 1'b1;
                            addr_d  = shift_q[SH_W-1 -: ADDR_W];
                            data_d  = shift_q[SH_W-1-ADDR_W -: DATA_W];
                            good_d  = good_q + 8'd1;
                        end else begin
                            crc_err_d = 1'b1;
                            err_d     = sat_inc8(err_q);
                        end
                    end
                end else if (gap_q == GAP_LAST) begin
                    gap_err_d = 1'b1;
                    err_d     = sat_inc8(err_q);
                    shift_d   = '0;
                    cnt_d     = '0;
                    gap_d     = '0;
                    crc_clr   = 1'b1;
                    state_d   = ST_IDLE;
                end else begin
                    gap_d = gap_q + CNT_W'(1);
                end
            end

            ST_CHECK: begin
                shift_d = '0;
                cnt_d   = '0;
                gap_d   = '0;
                crc_clr = 1'b1;
                state_d = ST_IDLE;
                if (bit_valid) begin
                    shift_d = {{(SH_W-1){1'b0}}, bit_data};
                    cnt_d   = CNT_BITS'(1);
                    crc_en  = 1'b1;
                    state_d = ST_RECV;
                end
            end

            default: begin
                shift_d = '0;
                cnt_d   = '0;
                gap_d   = '0;
                crc_clr = 1'b1;
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, datapath and output registers
    always_ff @(posedge bclk or negedge rstb) begin
        if (!rstb) begin
            state_q   <= ST_IDLE;
            shift_q   <= '0;
            cnt_q     <= '0;
            gap_q     <= '0;
            addr_q    <= '0;
            data_q    <= '0;
            latch_q   <= 1'b0;
            crc_err_q <= 1'b0;
            gap_err_q <= 1'b0;
            good_q    <= '0;
            err_q     <= '0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            cnt_q     <= cnt_d;
            gap_q     <= gap_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            latch_q   <= latch_d;
            crc_err_q <= crc_err_d;
            gap_err_q <= gap_err_d;
            good_q    <= good_d;
            err_q     <= err_d;
        end
    end

    assign addrOut  = addr_q;
    assign dataOut  = data_q;
    assign latchOut = latch_q;
    assign crc_err  = crc_err_q;
    assign gap_err  = gap_err_q;
    assign good_cnt = good_q;
    assign err_cnt  = err_q;

endmodule

// File: tb/tb_cmd_frame_deser.sv
// Bench for cmd_frame_deser: directed frames drive a scoreboard queue,
// a free-running monitor checks every strobe/error pulse against it.
module tb_cmd_frame_deser;

    localparam int GAP_T = 1024;

    logic        bclk;
    logic        rstb;
    logic        bit_valid;
    logic        bit_data;
    logic [7:0]  addrOut;
    logic [31:0] dataOut;
    logic        latchOut;
    logic        crc_err;
    logic        gap_err;
    logic [7:0]  good_cnt;
    logic [7:0]  err_cnt;

    cmd_frame_deser #(.GAP_TIMEOUT(GAP_T), .CNT_W(11), .CRC_POLY(8'h07)) dut (
        .bclk      (bclk),
        .rstb      (rstb),
        .bit_valid (bit_valid),
        .bit_data  (bit_data),
        .addrOut   (addrOut),
        .dataOut   (dataOut),
        .latchOut  (latchOut),
        .crc_err   (crc_err),
        .gap_err   (gap_err),
        .good_cnt  (good_cnt),
        .err_cnt   (err_cnt)
    );

    initial begin
        bclk = 1'b0;
        forever #5 bclk = ~bclk;
    end

    int cyc = 0;
    always @(posedge bclk) cyc <= cyc + 1;

    // kind: 0 latchOut, 1 crc_err, 2 gap_err
    typedef struct {
        int          kind;
        longint      at;
        logic [7:0]  a;
        logic [31:0] d;
        logic [7:0]  g;
        logic [7:0]  e;
    } exp_t;

    exp_t q[$];

    int n_vec = 0;
    int n_err = 0;

    logic [7:0]  exp_addr = 8'h00;
    logic [31:0] exp_data = 32'h0;
    logic [7:0]  exp_good = 8'h00;
    logic [7:0]  exp_errc = 8'h00;
    int          last_drive = 0;

    task automatic chk(input string nm, input longint act, input longint exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic logic [7:0] crc_model(input logic [39:0] m);
        logic [7:0] c;
        logic       fb;
        c = 8'h00;
        for (int i = 39; i >= 0; i--) begin
            fb = c[7] ^ m[i];
            c  = {c[6:0], 1'b0};
            if (fb) c = c ^ 8'h07;
        end
        return c;
    endfunction

    task automatic push(input int kind, input longint at);
        exp_t e;
        if (kind == 0) exp_good = exp_good + 8'd1;
        else           exp_errc = (exp_errc == 8'hFF) ? 8'hFF : exp_errc + 8'd1;
        e.kind = kind; e.at = at; e.a = exp_addr; e.d = exp_data;
        e.g = exp_good; e.e = exp_errc;
        q.push_back(e);
    endtask

    // Full frame; bits are `gap` idle cycles apart
    task automatic send_frame(input logic [7:0] a, input logic [31:0] d,
                              input logic [7:0] c, input int gap);
        logic [47:0] f;
        f = {a, d, c};
        for (int i = 0; i < 48; i++) begin
            @(negedge bclk);
            bit_valid = 1'b1;
            bit_data  = f[47-i];
            if (i == 47) begin
                if (c == crc_model({a, d})) begin
                    exp_addr = a;
                    exp_data = d;
                    push(0, cyc + 1);
                end else begin
                    push(1, cyc + 1);
                end
            end
            for (int k = 0; k < gap; k++) begin
                @(negedge bclk);
                bit_valid = 1'b0;
            end
        end
    endtask

    task automatic send_partial(input logic [47:0] f, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge bclk);
            bit_valid  = 1'b1;
            bit_data   = f[47-i];
            last_drive = cyc;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge bclk);
            bit_valid = 1'b0;
        end
    endtask

    task automatic do_reset();
        @(negedge bclk);
        bit_valid = 1'b0;
        rstb      = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge bclk);
            chk("rst_addr",  addrOut,  0);
            chk("rst_data",  dataOut,  0);
            chk("rst_latch", latchOut, 0);
            chk("rst_crc",   crc_err,  0);
            chk("rst_gap",   gap_err,  0);
            chk("rst_good",  good_cnt, 0);
            chk("rst_errc",  err_cnt,  0);
        end
        rstb     = 1'b1;
        exp_addr = 8'h00;
        exp_data = 32'h0;
        exp_good = 8'h00;
        exp_errc = 8'h00;
    endtask

    // Monitor: compare every presented pulse against the queue head
    initial begin
        logic [7:0]  pa;
        logic [31:0] pd;
        logic        pp;
        int          np;
        int          kind;
        exp_t        e;
        pa = '0; pd = '0; pp = 1'b0;
        forever begin
            @(posedge bclk);
            #1;
            if (!rstb) begin
                pa = '0; pd = '0; pp = 1'b0;
            end else begin
                np = int'(latchOut) + int'(crc_err) + int'(gap_err);
                if (!latchOut) begin
                    chk("hold_addr", addrOut, pa);
                    chk("hold_data", dataOut, pd);
                end
                if (np != 0) begin
                    chk("pulse_excl", np, 1);
                    chk("pulse_width", pp, 0);
                    kind = latchOut ? 0 : (crc_err ? 1 : 2);
                    if (q.size() == 0) begin
                        chk("unexpected_pulse", kind + 1, 0);
                    end else begin
                        e = q.pop_front();
                        chk("kind",     kind,     e.kind);
                        chk("latency",  cyc,      e.at);
                        chk("addrOut",  addrOut,  e.a);
                        chk("dataOut",  dataOut,  e.d);
                        chk("good_cnt", good_cnt, e.g);
                        chk("err_cnt",  err_cnt,  e.e);
                    end
                end
                pa = addrOut; pd = dataOut; pp = (np != 0);
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, %0d entries pending", q.size());
        $fatal(1, "watchdog");
    end

    initial begin
        logic [47:0] f;
        logic [7:0]  a;
        logic [31:0] d;
        rstb = 1'b0; bit_valid = 1'b0; bit_data = 1'b0;
        do_reset();
        idle(3);

        // Known-good frame, bits 4 cycles apart
        send_frame(8'h01, 32'h0, 8'h62, 3);
        idle(10);
        // Same frame with a corrupted CRC
        send_frame(8'h01, 32'h0, 8'h63, 3);
        idle(10);

        // Gap timeout after bit 20, then a good frame
        f = {8'hA5, 32'h12345678, crc_model({8'hA5, 32'h12345678})};
        send_partial(f, 20);
        push(2, last_drive + 1 + GAP_T);
        idle(GAP_T + 20);
        send_frame(8'h5A, 32'hDEADBEEF, crc_model({8'h5A, 32'hDEADBEEF}), 1);
        idle(5);

        // Back-to-back, frame 2 bit 1 lands in the CHECK cycle
        send_frame(8'h11, 32'hCAFEF00D, crc_model({8'h11, 32'hCAFEF00D}), 0);
        send_frame(8'h22, 32'h0BADF00D, crc_model({8'h22, 32'h0BADF00D}), 0);
        idle(5);

        // Reset at bit 30, then a good frame
        f = {8'h3C, 32'h87654321, crc_model({8'h3C, 32'h87654321})};
        send_partial(f, 30);
        do_reset();
        send_frame(8'h3C, 32'h87654321, crc_model({8'h3C, 32'h87654321}), 0);
        idle(5);

        // err_cnt saturation
        for (int i = 0; i < 260; i++) begin
            a = 8'(i);
            d = 32'(i) * 32'h01010101;
            send_frame(a, d, crc_model({a, d}) ^ 8'h01, 0);
        end
        idle(5);

        // good_cnt wrap
        do_reset();
        for (int i = 0; i < 257; i++) begin
            a = 8'(i + 7);
            d = 32'(i) * 32'h9E3779B9;
            send_frame(a, d, crc_model({a, d}), 0);
        end
        idle(5);

        for (int i = 0; i < 200 && q.size() != 0; i++) @(negedge bclk);
        chk("drain", q.size(), 0);
        chk("final_good_cnt", good_cnt, 1);
        chk("final_err_cnt",  err_cnt,  0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
